// File: rtl/sub64_pipe.sv
// sub64_pipe: four-stage pipelined 64-bit subtractor, d = a - b - bin.
//
// The borrow chain is cut into four 16-bit slices. Each slice is evaluated as
// a + ~b + carry, where carry is the complement of the borrow. One slice is
// resolved per register stage, so the latency is four cycles and the
// throughput is one result per cycle. Stage 4 registers drive the outputs
// directly.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   a, b, bin  minuend, subtrahend and borrow-in (sampled on the accept edge)
//   in_valid   operands valid
//   in_ready   block accepts an operation this cycle (= ~out_valid | out_ready)
//   d          64-bit difference
//   bout       borrow-out, 1 iff unsigned a < b + bin
//   ovf        two's-complement overflow of the signed subtraction
//   out_valid  d/bout/ovf valid
//   out_ready  consumer accepts the result
//
// Build option:
//   SUB64_SAT_EN  when defined, d is clamped to the signed limit on overflow.
//                 The sign of the limit follows a[63]. ovf and bout are
//                 unchanged.

module sub64_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        bin,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] d,
  output logic        bout,
  output logic        ovf,
  output logic        out_valid,
  input  logic        out_ready
);

  // 16-bit slice of a + ~b + cin; bit 16 is the carry-out.
  function automatic logic [16:0] slice_add(input logic [15:0] x,
                                            input logic [15:0] y,
                                            input logic        cin);
    return {1'b0, x} + {1'b0, ~y} + {16'd0, cin};
  endfunction

  // Stage 1: slice 0 resolved, a/b[63:16] pending.
  logic [15:0] s1_diff_q, s1_diff_d;
  logic        s1_c_q,    s1_c_d;
  logic [47:0] s1_a_q,    s1_a_d;
  logic [47:0] s1_b_q,    s1_b_d;
  logic        s1_v_q,    s1_v_d;
  // Stage 2: slices 0..1 resolved, a/b[63:32] pending.
  logic [31:0] s2_diff_q, s2_diff_d;
  logic        s2_c_q,    s2_c_d;
  logic [31:0] s2_a_q,    s2_a_d;
  logic [31:0] s2_b_q,    s2_b_d;
  logic        s2_v_q,    s2_v_d;
  // Stage 3: slices 0..2 resolved, a/b[63:48] pending.
  logic [47:0] s3_diff_q, s3_diff_d;
  logic        s3_c_q,    s3_c_d;
  logic [15:0] s3_a_q,    s3_a_d;
  logic [15:0] s3_b_q,    s3_b_d;
  logic        s3_v_q,    s3_v_d;
  // Stage 4: output registers.
  logic [63:0] d_q,    d_d;
  logic        bout_q, bout_d;
  logic        ovf_q,  ovf_d;
  logic        ov_q,   ov_d;

  logic        adv;
  logic [16:0] sum0, sum1, sum2, sum3;
  logic [15:0] lo15;

  // The whole pipe moves as one: a stalled output freezes every stage,
  // including the empty ones.
  assign adv      = ~ov_q | out_ready;
  assign in_ready = adv;

  always_comb begin
    sum0 = slice_add(a[15:0],       b[15:0],       ~bin);
    sum1 = slice_add(s1_a_q[15:0],  s1_b_q[15:0],  s1_c_q);
    sum2 = slice_add(s2_a_q[15:0],  s2_b_q[15:0],  s2_c_q);
    sum3 = slice_add(s3_a_q,        s3_b_q,        s3_c_q);
    // Low 15 bits of the top slice give the carry into bit 63.
    lo15 = {1'b0, s3_a_q[14:0]} + {1'b0, ~s3_b_q[14:0]} + {15'd0, s3_c_q};

    s1_diff_d = sum0[15:0];
    s1_c_d    = sum0[16];
    s1_a_d    = a[63:16];
    s1_b_d    = b[63:16];
    s1_v_d    = in_valid & in_ready;

    s2_diff_d = {sum1[15:0], s1_diff_q};
    s2_c_d    = sum1[16];
    s2_a_d    = s1_a_q[47:16];
    s2_b_d    = s1_b_q[47:16];
    s2_v_d    = s1_v_q;

    s3_diff_d = {sum2[15:0], s2_diff_q};
    s3_c_d    = sum2[16];
    s3_a_d    = s2_a_q[31:16];
    s3_b_d    = s2_b_q[31:16];
    s3_v_d    = s2_v_q;

    d_d    = {sum3[15:0], s3_diff_q};
    bout_d = ~sum3[16];
    ovf_d  = lo15[15] ^ sum3[16];
    ov_d   = s3_v_q;
`ifdef SUB64_SAT_EN
    if (ovf_d) begin
      d_d = s3_a_q[15] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_diff_q <= '0; s1_c_q <= 1'b0; s1_a_q <= '0; s1_b_q <= '0; s1_v_q <= 1'b0;
      s2_diff_q <= '0; s2_c_q <= 1'b0; s2_a_q <= '0; s2_b_q <= '0; s2_v_q <= 1'b0;
      s3_diff_q <= '0; s3_c_q <= 1'b0; s3_a_q <= '0; s3_b_q <= '0; s3_v_q <= 1'b0;
      d_q       <= '0; bout_q <= 1'b0; ovf_q  <= 1'b0; ov_q   <= 1'b0;
    end else if (adv) begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      s3_v_q <= s3_v_d;
      ov_q   <= ov_d;
      // Data registers only load behind a valid token, so bubbles do not toggle them.
      if (s1_v_d) begin
        s1_diff_q <= s1_diff_d; s1_c_q <= s1_c_d; s1_a_q <= s1_a_d; s1_b_q <= s1_b_d;
      end
      if (s2_v_d) begin
        s2_diff_q <= s2_diff_d; s2_c_q <= s2_c_d; s2_a_q <= s2_a_d; s2_b_q <= s2_b_d;
      end
      if (s3_v_d) begin
        s3_diff_q <= s3_diff_d; s3_c_q <= s3_c_d; s3_a_q <= s3_a_d; s3_b_q <= s3_b_d;
      end
      if (ov_d) begin
        d_q <= d_d; bout_q <= bout_d; ovf_q <= ovf_d;
      end
    end
  end

  assign d         = d_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign out_valid = ov_q;

endmodule

// File: tb/tb_sub64_pipe.sv
// Bench for sub64_pipe: an arithmetic reference model with a scoreboard queue,
// checked every cycle by a negedge monitor, plus directed literal vectors.

module tb_sub64_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] a, b;
  logic        bin, in_valid, in_ready;
  logic [63:0] d;
  logic        bout, ovf, out_valid, out_ready;

  sub64_pipe dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .bin(bin),
    .in_valid(in_valid), .in_ready(in_ready),
    .d(d), .bout(bout), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic        bout;
    logic        ovf;
  } exp_t;

  localparam logic signed [65:0] SMAX = 66'sd9223372036854775807;
  localparam logic signed [65:0] SMIN = -66'sd9223372036854775808;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned n_out = 0;
  exp_t        q[$];

  // Reference: plain unsigned and signed arithmetic on wide integers.
  function automatic exp_t model(input logic [63:0] av, input logic [63:0] bv, input logic bi);
    exp_t m;
    logic [64:0]        u;
    logic signed [65:0] s;
    u = {1'b0, av} - {1'b0, bv} - {64'd0, bi};
    s = $signed({{2{av[63]}}, av}) - $signed({{2{bv[63]}}, bv}) - $signed({65'd0, bi});
    m.d    = u[63:0];
    m.bout = u[64];
    m.ovf  = (s > SMAX) || (s < SMIN);
`ifdef SUB64_SAT_EN
    if (m.ovf) m.d = (s < 0) ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
    return m;
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Monitor: values seen at negedge are those sampled by the next rising edge.
  logic        prev_stall = 1'b0;
  logic [63:0] sv_d;
  logic        sv_bout, sv_ovf, sv_ov;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready", {63'd0, in_ready}, {63'd0, ~(out_valid & ~out_ready)});
      if (prev_stall) begin
        check("stall d",         d,                  sv_d);
        check("stall bout",      {63'd0, bout},      {63'd0, sv_bout});
        check("stall ovf",       {63'd0, ovf},       {63'd0, sv_ovf});
        check("stall out_valid", {63'd0, out_valid}, {63'd0, sv_ov});
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected result: got d=%h, expected no output at %0t", d, $time);
        end else begin
          e = q.pop_front();
          check("sb d",    d,             e.d);
          check("sb bout", {63'd0, bout}, {63'd0, e.bout});
          check("sb ovf",  {63'd0, ovf},  {63'd0, e.ovf});
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, bin));
      prev_stall = out_valid & ~out_ready;
      sv_d = d; sv_bout = bout; sv_ovf = ovf; sv_ov = out_valid;
    end
  end

  // Directed single op: pins the model to literals, then checks latency and DUT.
  task automatic run_one(input string nm, input logic [63:0] av, input logic [63:0] bv,
                         input logic bi, input logic [63:0] ed, input logic eb, input logic eo);
    exp_t m;
    int unsigned n;
    m = model(av, bv, bi);
    check({nm, " model d"},    m.d,             ed);
    check({nm, " model bout"}, {63'd0, m.bout}, {63'd0, eb});
    check({nm, " model ovf"},  {63'd0, m.ovf},  {63'd0, eo});
    out_ready = 1'b1;
    a = av; b = bv; bin = bi; in_valid = 1'b1;
    check({nm, " in_ready"}, {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~av; b = ~bv; bin = ~bi;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, " latency"}, 64'(n), 64'd4);
    check({nm, " d"},    d,             ed);
    check({nm, " bout"}, {63'd0, bout}, {63'd0, eb});
    check({nm, " ovf"},  {63'd0, ovf},  {63'd0, eo});
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    int unsigned sent, cyc, base, seen;
    rst_n = 1'b0; a = '0; b = '0; bin = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset d",         d,                  64'd0);
    check("reset bout",      {63'd0, bout},      64'd0);
    check("reset ovf",       {63'd0, ovf},       64'd0);
    check("reset in_ready",  {63'd0, in_ready},  64'd1);

    run_one("basic",   64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0);
    run_one("under1",  64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run_one("under2",  64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run_one("xslice",  64'h0001_0000_0000_0000, 64'd1, 1'b0, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_one("mixed",   64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1,
            64'h0246_8ACF_1357_9BCE, 1'b0, 1'b0);
`ifdef SUB64_SAT_EN
    run_one("negovf",  64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_one("posovf",  64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
            64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
`else
    run_one("negovf",  64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    run_one("posovf",  64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
            64'h8000_0000_0000_0000, 1'b1, 1'b1);
`endif

    // Back-to-back random ops under pseudo-random backpressure.
    base = n_out;
    sent = 0;
    cyc  = 0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; bin = 1'($urandom);
    in_valid = 1'b1;
    while (sent < 16 && cyc < 500) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      cyc++;
      out_ready = 1'($urandom);
      if (acc) begin
        sent++;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; bin = 1'($urandom);
      end
      if (sent == 16) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    while (q.size() != 0 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
      out_ready = 1'($urandom);
    end
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("bp results", 64'(n_out - base), 64'd16);

    // Reset with three operations in flight.
    for (int unsigned i = 0; i < 3; i++) begin
      a = 64'(100 + i); b = 64'd7; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst out_valid", {63'd0, out_valid}, 64'd0);
    check("rst in_ready",  {63'd0, in_ready},  64'd1);
    seen = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("rst no results", 64'(seen), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
